bram_fifo: RTL and testbench

BRAM_FIFO -- requirements
Module: bram_fifo

---
 rtl/bram_fifo.sv | 96 +++++++++
 tb/tb_bram_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo.sv
// First-word-fall-through FIFO built on an inferred simple dual-port block RAM,
// a registered RAM read stage and a DATA_WIDTH output register holding the head word.
module bram_fifo #(
  parameter int DATA_WIDTH    = 96,
  parameter int DEPTH         = 256,
  parameter int ADDR_WIDTH    = $clog2(DEPTH),
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   ram_count;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  q_valid;
  logic                  do_write;
  logic                  do_pop;
  logic                  load_out;
  logic                  do_read;

  // ram_count only holds words already committed, so a word is never read on
  // the edge that writes it; the read stage refills as soon as it is drained.
  assign do_write = wr_en && !full && !rst;
  assign do_pop   = rd_en && rd_valid;
  assign load_out = q_valid && (!rd_valid || do_pop);
  assign do_read  = (ram_count != '0) && (!q_valid || load_out);

  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (do_read) ram_q <= mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      q_valid   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && !rd_valid;

      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_read)  rd_ptr <= rd_ptr + 1'b1;

      if (do_write && !do_read)      ram_count <= ram_count + 1'b1;
      else if (!do_write && do_read) ram_count <= ram_count - 1'b1;

      if (do_read)       q_valid <= 1'b1;
      else if (load_out) q_valid <= 1'b0;

      if (load_out) begin
        rd_valid <= 1'b1;
        rd_data  <= ram_q;
      end else if (do_pop) begin
        rd_valid <= 1'b0;
      end

      if (do_write && !do_pop)      count <= count + 1'b1;
      else if (!do_write && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_bram_fifo.sv
// Self-checking bench for bram_fifo: directed scenarios plus random traffic,
// compared against a queue model that tracks when each word becomes visible.
module tb_bram_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int AFULL = 12;
  localparam int AEMPT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          almost_full;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [DW-1:0] d;
    int            we;
  } ent_t;

  ent_t mq[$];
  int   cur      = 0;
  int   last_pop = -100;

  bram_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPT)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .almost_full(almost_full), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // The head word shows up two edges after its write, but never before the
  // edge that popped the word ahead of it.
  function automatic bit head_visible(int e);
    int t;
    if (mq.size() == 0) return 1'b0;
    t = mq[0].we + 2;
    if (last_pop > t) t = last_pop;
    return e >= t;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s at edge %0d: observed=%0h expected=%0h", tag, cur, obs, exp);
    end
  endtask

  task automatic checkState(input bit ovf, input bit unf);
    int  n;
    bit  v;
    n = mq.size();
    v = head_visible(cur);
    checkOutput("rd_valid", 32'(rd_valid), 32'(v));
    checkOutput("count", 32'(count), 32'(n));
    checkOutput("full", 32'(full), 32'(n == DEPTH));
    checkOutput("almost_full", 32'(almost_full), 32'(n >= AFULL));
    checkOutput("almost_empty", 32'(almost_empty), 32'(n <= AEMPT));
    checkOutput("overflow", 32'(overflow), 32'(ovf));
    checkOutput("underflow", 32'(underflow), 32'(unf));
    if (v) checkOutput("rd_data", 32'(rd_data), 32'(mq[0].d));
  endtask

  task automatic applyStimulus(input logic wr, input logic [DW-1:0] d, input logic rd);
    bit pop_acc, wr_acc, ovf, unf;
    ent_t e;
    pop_acc = rd && head_visible(cur);
    wr_acc  = wr && (mq.size() < DEPTH);
    ovf     = wr && (mq.size() == DEPTH);
    unf     = rd && !head_visible(cur);
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    @(posedge clk);
    cur++;
    if (pop_acc) begin
      void'(mq.pop_front());
      last_pop = cur;
    end
    if (wr_acc) begin
      e.d  = d;
      e.we = cur;
      mq.push_back(e);
    end
    #1;
    checkState(ovf, unf);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_almost_full", 32'(almost_full), 32'd0);
    checkOutput("rst_almost_empty", 32'(almost_empty), 32'd1);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_underflow", 32'(underflow), 32'd0);
  endtask

  initial begin
    int pct;
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    cur = 2;
    checkResetValues();
    rst = 1'b0;

    $display("[TB] single word");
    applyStimulus(1'b1, 16'h00A5, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);

    $display("[TB] underflow");
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);

    $display("[TB] fill and overflow");
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 16'(16'h100 + i), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b1, 16'hDEAD, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, 1'b1);

    $display("[TB] streaming across wrap");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'(16'h200 + i), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    for (int i = 8; i < 48; i++) applyStimulus(1'b1, 16'(16'h200 + i), 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      case (i / 100)
        0:       pct = 70;
        1:       pct = 30;
        2:       pct = 50;
        default: pct = 90;
      endcase
      applyStimulus($urandom_range(0, 99) < pct, 16'($urandom),
                    $urandom_range(0, 99) < (100 - pct / 2));
    end

    $display("[TB] reset mid-operation");
    while (mq.size() > 0) applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 16'(16'h300 + i), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("pre_rst_count", 32'(count), 32'd9);
    checkOutput("pre_rst_rd_valid", 32'(rd_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkResetValues();
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 16'hBEEF;
    @(posedge clk);
    cur++;
    #1;
    checkResetValues();
    mq.delete();
    last_pop = -100;
    rst = 1'b0;
    applyStimulus(1'b1, 16'h003C, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("post_rst_data", 32'(rd_data), 32'h3C);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
